contrast_ram_sequencer: RTL and testbench

//  Frame sequencer for the contrast-stretching pixel RAM. On start it copies one frame from the image ROM

---
 rtl/contrast_ram_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_contrast_ram_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contrast_ram_sequencer.sv
// contrast_ram_sequencer
//   Frame sequencer for the contrast-stretch pixel RAM. A start in IDLE copies
//   one frame from the image ROM into the RAM while tracking the unsigned pixel
//   min/max, then streams the frame back out of the RAM through a 2-entry skid
//   buffer on a valid/ready interface.
// Ports
//   clk_i_top, rst_i_top        : clock, synchronous active-high reset
//   start_i                     : start one frame (honoured only in IDLE)
//   rom_addr_o / rom_data_i     : image ROM, data returns one cycle after address
//   ram_en_o/we_o/re_o/addr_o   : pixel RAM control
//   ram_data_o / ram_data_i     : RAM write data / read data (one cycle latency)
//   pix_valid_o/ready_i/data_o/last_o : output pixel stream
//   min_o, max_o, stats_valid_o : frame statistics
//   busy_o, done_o              : busy in LOAD/READ, one-cycle done pulse
module contrast_ram_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 76800,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk_i_top,
  input  logic                  rst_i_top,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic                  ram_re_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  output logic                  pix_last_o,
  output logic [DATA_WIDTH-1:0] min_o,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic                  stats_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C     = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE_C  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR_C = ADDR_WIDTH'(RAM_DEPTH-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  // Shared address counter: ROM issue count in LOAD (0..RAM_DEPTH),
  // RAM read issue count in READ.
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] min_q, min_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic                  stats_valid_q, stats_valid_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
  logic                  tail_last_q, tail_last_d;

  logic                  pop;
  logic                  issue;
  logic [1:0]            occ_after;
  logic [2:0]            credit_used;

  assign pix_valid_o   = (occ_q != 2'd0);
  assign pix_data_o    = pix_valid_o ? head_data_q : '0;
  assign pix_last_o    = pix_valid_o & head_last_q;
  assign min_o         = min_q;
  assign max_o         = max_q;
  assign stats_valid_o = stats_valid_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    min_d           = min_q;
    max_d           = max_q;
    stats_valid_d   = stats_valid_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    occ_d           = occ_q;
    head_data_d     = head_data_q;
    head_last_d     = head_last_q;
    tail_data_d     = tail_data_q;
    tail_last_d     = tail_last_q;

    rom_addr_o = '0;
    ram_en_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_re_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;

    pop         = pix_valid_o & pix_ready_i;
    occ_after   = occ_q - {1'b0, pop};
    // Credit: buffered entries left after this cycle's pop plus the read
    // already in flight must leave room for one more entry.
    credit_used = {1'b0, occ_after} + {2'b00, inflight_q};
    issue       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d       = S_LOAD;
          cnt_d         = '0;
          min_d         = '1;
          max_d         = '0;
          stats_valid_d = 1'b0;
        end
      end

      S_LOAD: begin
        busy_o = 1'b1;
        if (cnt_q < DEPTH_C) begin
          rom_addr_o = cnt_q[ADDR_WIDTH-1:0];
        end
        // ROM data for the address issued last cycle is written this cycle.
        if (cnt_q != '0) begin
          ram_en_o   = 1'b1;
          ram_we_o   = 1'b1;
          ram_addr_o = cnt_q[ADDR_WIDTH-1:0] - ADDR_ONE_C;
          ram_data_o = rom_data_i;
          if (rom_data_i < min_q) min_d = rom_data_i;
          if (rom_data_i > max_q) max_d = rom_data_i;
        end
        if (cnt_q == DEPTH_C) begin
          state_d       = S_READ;
          cnt_d         = '0;
          stats_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE_C;
        end
      end

      S_READ: begin
        busy_o = 1'b1;
        issue  = (credit_used < 3'd2) && (cnt_q < DEPTH_C);
        // Enable stays up on the capture cycle so the RAM holds its output.
        ram_en_o   = issue | inflight_q;
        ram_re_o   = issue;
        ram_addr_o = cnt_q[ADDR_WIDTH-1:0];
        if (issue) begin
          cnt_d           = cnt_q + CNT_ONE_C;
          inflight_d      = 1'b1;
          inflight_last_d = (cnt_q[ADDR_WIDTH-1:0] == LAST_ADDR_C);
        end

        unique case ({inflight_q, pop})
          2'b01: begin
            head_data_d = tail_data_q;
            head_last_d = tail_last_q;
            occ_d       = occ_q - 2'd1;
          end
          2'b10: begin
            if (occ_q == 2'd0) begin
              head_data_d = ram_data_i;
              head_last_d = inflight_last_q;
            end else begin
              tail_data_d = ram_data_i;
              tail_last_d = inflight_last_q;
            end
            occ_d = occ_q + 2'd1;
          end
          2'b11: begin
            // Simultaneous capture and pop: new data lands behind the
            // surviving entry, occupancy unchanged.
            if (occ_q == 2'd1) begin
              head_data_d = ram_data_i;
              head_last_d = inflight_last_q;
            end else begin
              head_data_d = tail_data_q;
              head_last_d = tail_last_q;
              tail_data_d = ram_data_i;
              tail_last_d = inflight_last_q;
            end
          end
          default: ;
        endcase

        if (pop && head_last_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
        occ_d   = 2'd0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i_top) begin
    if (rst_i_top) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      min_q           <= '1;
      max_q           <= '0;
      stats_valid_q   <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      head_data_q     <= '0;
      head_last_q     <= 1'b0;
      tail_data_q     <= '0;
      tail_last_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      min_q           <= min_d;
      max_q           <= max_d;
      stats_valid_q   <= stats_valid_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      occ_q           <= occ_d;
      head_data_q     <= head_data_d;
      head_last_q     <= head_last_d;
      tail_data_q     <= tail_data_d;
      tail_last_q     <= tail_last_d;
    end
  end

endmodule

// File: tb/tb_contrast_ram_sequencer.sv
// Directed bench for contrast_ram_sequencer with a 16-pixel frame, a model
// ROM (one-cycle read latency) and a model RAM whose read port clears when
// the enable drops.
module tb_contrast_ram_sequencer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          ram_en, ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [DW-1:0] pix_data;
  logic          pix_last;
  logic [DW-1:0] min_v, max_v;
  logic          stats_valid, busy, done;

  logic [DW-1:0] rom_mem [DEPTH];
  logic [DW-1:0] ram_mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  contrast_ram_sequencer #(
    .DATA_WIDTH(DW),
    .RAM_DEPTH (DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i_top    (clk),
    .rst_i_top    (rst),
    .start_i      (start),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .ram_en_o     (ram_en),
    .ram_we_o     (ram_we),
    .ram_re_o     (ram_re),
    .ram_addr_o   (ram_addr),
    .ram_data_o   (ram_wdata),
    .ram_data_i   (ram_rdata),
    .pix_valid_o  (pix_valid),
    .pix_ready_i  (pix_ready),
    .pix_data_o   (pix_data),
    .pix_last_o   (pix_last),
    .min_o        (min_v),
    .max_o        (max_v),
    .stats_valid_o(stats_valid),
    .busy_o       (busy),
    .done_o       (done)
  );

  always @(posedge clk) begin
    rom_data <= rom_mem[rom_addr];
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram_mem[ram_addr];
    end else begin
      ram_rdata <= '0;
    end
  end

  task automatic set_rom_ramp();
    for (int k = 0; k < DEPTH; k++) rom_mem[k] = 8'(10 + 3 * k);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ram_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_ram_en cycle=%0d got=%b exp=0", c, ram_en);
      end
    end
    checks++;
    if ({pix_valid, pix_last, pix_data, max_v, stats_valid, busy, done,
         ram_we, ram_re, ram_addr, ram_wdata, rom_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b last=%b data=%0h max=%0h sv=%b busy=%b done=%b we=%b re=%b exp all zero",
               pix_valid, pix_last, pix_data, max_v, stats_valid, busy, done, ram_we, ram_re);
    end
    checks++;
    if (min_v !== 8'hFF) begin
      failures++;
      $display("FAIL reset_min got=%0h exp=ff", min_v);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [DW-1:0] e;
    set_rom_ramp();
    pix_ready = 1'b1;
    pulse_start();
    // LOAD cycle 0: address 0 issued, nothing written yet
    checks++;
    if (rom_addr !== 4'd0 || ram_en !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL load_first got rom_addr=%0d en=%b busy=%b exp 0/0/1", rom_addr, ram_en, busy);
    end
    checks++;
    if (min_v !== 8'hFF || max_v !== 8'h00 || stats_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_stats_clear got min=%0h max=%0h sv=%b exp ff/00/0", min_v, max_v, stats_valid);
    end
    for (int j = 1; j <= DEPTH; j++) begin
      @(negedge clk);
      e = 8'(10 + 3 * (j - 1));
      checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_re !== 1'b0) begin
        failures++;
        $display("FAIL load_ctrl j=%0d got en=%b we=%b re=%b exp 1/1/0", j, ram_en, ram_we, ram_re);
      end
      checks++;
      if (ram_addr !== 4'(j - 1) || ram_wdata !== e) begin
        failures++;
        $display("FAIL load_write j=%0d got addr=%0d data=%0d exp addr=%0d data=%0d",
                 j, ram_addr, ram_wdata, j - 1, e);
      end
      if (j < DEPTH) begin
        checks++;
        if (rom_addr !== 4'(j) || stats_valid !== 1'b0) begin
          failures++;
          $display("FAIL load_rom_addr j=%0d got=%0d sv=%b exp=%0d sv=0", j, rom_addr, stats_valid, j);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (stats_valid !== 1'b1 || min_v !== 8'd10 || max_v !== 8'd55 || busy !== 1'b1) begin
      failures++;
      $display("FAIL load_stats got sv=%b min=%0d max=%0d busy=%b exp 1/10/55/1", stats_valid, min_v, max_v, busy);
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (ram_mem[k] !== 8'(10 + 3 * k)) begin
        failures++;
        $display("FAIL ram_content addr=%0d got=%0d exp=%0d", k, ram_mem[k], 10 + 3 * k);
      end
    end
  endtask

  // Continues from the first READ cycle left by test_load.
  task automatic test_stream();
    checks++;
    if (pix_valid !== 1'b0 || ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 4'd0) begin
      failures++;
      $display("FAIL read_first got valid=%b re=%b we=%b addr=%0d exp 0/1/0/0", pix_valid, ram_re, ram_we, ram_addr);
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_latency got valid=%b exp=0", pix_valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (pix_valid !== 1'b1 || pix_data !== 8'(10 + 3 * i)) begin
        failures++;
        $display("FAIL stream_pix i=%0d got valid=%b data=%0d exp valid=1 data=%0d", i, pix_valid, pix_data, 10 + 3 * i);
      end
      checks++;
      if (pix_last !== (i == DEPTH - 1)) begin
        failures++;
        $display("FAIL stream_last i=%0d got=%b exp=%b", i, pix_last, i == DEPTH - 1);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse got done=%b busy=%b valid=%b exp 1/0/0", done, busy, pix_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || stats_valid !== 1'b1 || min_v !== 8'd10 || max_v !== 8'd55) begin
      failures++;
      $display("FAIL idle_after got done=%b busy=%b sv=%b min=%0d max=%0d exp 0/0/1/10/55",
               done, busy, stats_valid, min_v, max_v);
    end
  endtask

  task automatic test_random_ready();
    int idx = 0;
    int outstanding = 0;
    int max_out = 0;
    bit done_seen = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    pix_ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      if (prev_stall) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== prev_data || pix_last !== prev_last) begin
          failures++;
          $display("FAIL stall_stable c=%0d got valid=%b data=%0d last=%b exp 1/%0d/%b",
                   c, pix_valid, pix_data, pix_last, prev_data, prev_last);
        end
      end
      pix_ready = 1'($urandom_range(0, 1));
      #1;
      if (ram_re) outstanding++;
      if (pix_valid && pix_ready) begin
        checks++;
        if (pix_data !== 8'(10 + 3 * idx) || pix_last !== (idx == DEPTH - 1)) begin
          failures++;
          $display("FAIL rand_pix idx=%0d got data=%0d last=%b exp data=%0d last=%b",
                   idx, pix_data, pix_last, 10 + 3 * idx, idx == DEPTH - 1);
        end
        idx++;
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_last  = pix_last;
    end
    pix_ready = 1'b1;
    checks++;
    if (!done_seen || idx != DEPTH) begin
      failures++;
      $display("FAIL rand_count got done=%b pixels=%0d exp done=1 pixels=%0d", done_seen, idx, DEPTH);
    end
    checks++;
    if (max_out > 2) begin
      failures++;
      $display("FAIL rand_credit got max_outstanding=%0d exp<=2", max_out);
    end
  endtask

  task automatic test_const_ignore();
    for (int k = 0; k < DEPTH; k++) rom_mem[k] = 8'h80;
    pix_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      int wr = 0;
      int pops = 0;
      bit done_seen = 1'b0;
      pulse_start();
      for (int c = 0; c < 200; c++) begin
        if (done) begin
          done_seen = 1'b1;
          break;
        end
        start = (c == 5 || c == 25);
        #1;
        if (ram_en && ram_we) begin
          checks++;
          if (ram_addr !== 4'(wr) || ram_re !== 1'b0) begin
            failures++;
            $display("FAIL const_wr_order f=%0d got addr=%0d re=%b exp addr=%0d re=0", f, ram_addr, ram_re, wr);
          end
          wr++;
        end
        if (pix_valid && pix_ready) begin
          checks++;
          if (pix_data !== 8'h80) begin
            failures++;
            $display("FAIL const_pix f=%0d got=%0h exp=80", f, pix_data);
          end
          pops++;
        end
        @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (!done_seen || wr != DEPTH || pops != DEPTH) begin
        failures++;
        $display("FAIL const_frame f=%0d got done=%b writes=%0d pixels=%0d exp 1/%0d/%0d",
                 f, done_seen, wr, pops, DEPTH, DEPTH);
      end
      checks++;
      if (min_v !== 8'h80 || max_v !== 8'h80 || stats_valid !== 1'b1) begin
        failures++;
        $display("FAIL const_stats f=%0d got min=%0h max=%0h sv=%b exp 80/80/1", f, min_v, max_v, stats_valid);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL const_idle f=%0d got busy=%b exp=0", f, busy);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int pops = 0;
    int idx = 0;
    set_rom_ramp();
    pix_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 100; c++) begin
      if (pix_valid) pops++;
      @(negedge clk);
      if (pops == 5) break;
    end
    checks++;
    if (pops != 5) begin
      failures++;
      $display("FAIL midrst_reach got pixels=%0d exp=5", pops);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || ram_en !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_out got valid=%b busy=%b en=%b done=%b exp 0/0/0/0", pix_valid, busy, ram_en, done);
    end
    checks++;
    if (min_v !== 8'hFF || max_v !== 8'h00 || stats_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_stats got min=%0h max=%0h sv=%b exp ff/00/0", min_v, max_v, stats_valid);
    end
    rst = 1'b0;
    pulse_start();
    for (int c = 0; c < 100; c++) begin
      if (done) break;
      if (pix_valid) begin
        checks++;
        if (pix_data !== 8'(10 + 3 * idx)) begin
          failures++;
          $display("FAIL replay_pix idx=%0d got=%0d exp=%0d", idx, pix_data, 10 + 3 * idx);
        end
        idx++;
      end
      @(negedge clk);
    end
    checks++;
    if (idx != DEPTH || done !== 1'b1) begin
      failures++;
      $display("FAIL replay_count got pixels=%0d done=%b exp %0d/1", idx, done, DEPTH);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_random_ready();
    test_const_ignore();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
